// File: rtl/shift_add_multiplier_pkg.sv
// Shared types for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus between the ALU controller and the multiplier.
interface shift_add_multiplier_if #(
  parameter int N = 4
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_adder.sv
// Unsigned N-bit ripple adder with carry-in and carry-out.
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] y,
  output logic         cout
);

  assign {cout, y} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier: one add/shift step per clock.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_add_multiplier_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  mul_state_t      state_r;
  mul_state_t      state_s;
  logic [N-1:0]    m_r;
  logic [N-1:0]    hi_r;
  logic [N-1:0]    lo_r;
  logic [CW-1:0]   count_r;
  logic            busy_r;
  logic            done_r;
  logic            load_s;
  logic [N-1:0]    sum_s;
  logic            cout_s;

  // hi + M each cycle; the carry lands in the MSB of the shifted hi, so nothing overflows.
  adder #(.N(N)) u_adder (
    .a    (hi_r),
    .b    (m_r),
    .cin  (1'b0),
    .y    (sum_s),
    .cout (cout_s)
  );

  // A start is only honoured outside RUN; DONE accepting it gives back-to-back operation.
  assign load_s = ((state_r == IDLE) || (state_r == DONE)) && bus.start;

  // Next-state decode; a corrupted count in RUN still terminates rather than spinning.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (count_r <= CW'(1)) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, registered status flags and the M/hi/lo/count datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      m_r     <= {N{1'b0}};
      hi_r    <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (load_s) begin
        m_r     <= bus.a;
        hi_r    <= {N{1'b0}};
        lo_r    <= bus.b;
        count_r <= CW'(N);
      end else if (state_r == RUN) begin
        if (lo_r[0]) begin
          {hi_r, lo_r} <= {cout_s, sum_s, lo_r[N-1:1]};
        end else begin
          {hi_r, lo_r} <= {1'b0, hi_r, lo_r[N-1:1]};
        end
        if (count_r != {CW{1'b0}}) begin
          count_r <= count_r - CW'(1);
        end else begin
          count_r <= count_r;
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = {hi_r, lo_r};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: driver pushes a*b with its due cycle, monitor pops on done.
module tb_shift_add_multiplier;

  localparam int N  = 4;
  localparam int PW = 2 * N;

  typedef struct {
    logic [PW-1:0] p;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a falling edge; the start is accepted at the next rising edge.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    e.p   = PW'(x) * PW'(y);
    e.due = cyc + 1 + N;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
  endtask

  // Monitor: every done must match the oldest outstanding request, on time.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("product", 64'(bus.product), 64'(mon_e.p));
        chk("done_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    int bc;
    logic [N-1:0] x;
    logic [N-1:0] y;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_product", 64'(bus.product), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero operands: full N steps, busy for exactly N cycles.
    issue(4'd0, 4'd0);
    bc = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (bus.busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(bc), 64'(N));

    // 5*6, product held after done.
    issue(4'd5, 4'd6);
    repeat (N) @(negedge clk);
    chk("done_pulse_30", 64'(bus.done), 64'd1);
    chk("product_30", 64'(bus.product), 64'h1E);
    repeat (3) @(negedge clk);
    chk("product_hold", 64'(bus.product), 64'h1E);
    chk("idle_after_done", 64'(bus.done), 64'd0);
    @(negedge clk);

    // Max operands exercise carry capture.
    issue(4'hF, 4'hF);
    repeat (N + 1) @(negedge clk);

    // Start while busy is ignored; only one done for 3*7.
    issue(4'd3, 4'd7);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N + 1) @(negedge clk);

    // Reset mid-operation discards the multiply.
    issue(4'hF, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_product", 64'(bus.product), 64'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (N + 3) @(negedge clk);

    // Back-to-back: start held in the DONE cycle.
    issue(4'd2, 4'd3);
    repeat (N) @(negedge clk);
    chk("b2b_first_done", 64'(bus.done), 64'd1);
    chk("b2b_first_product", 64'(bus.product), 64'd6);
    issue(4'd4, 4'd4);
    repeat (N + 1) @(negedge clk);

    // Randomised operands, mixing back-to-back and idle gaps.
    for (int i = 0; i < 24; i++) begin
      x = N'($urandom_range(0, (1 << N) - 1));
      y = N'($urandom_range(0, (1 << N) - 1));
      issue(x, y);
      if ($urandom_range(0, 1) == 1) repeat (N) @(negedge clk);
      else repeat (N + 1 + $urandom_range(0, 2)) @(negedge clk);
    end
    repeat (N + 2) @(negedge clk);

    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
